// File: rtl/jt12_slot_pkg.sv
// Shared slot-code widths, frame constants and helpers for the FM slot sequencer.
// The optional illegal-code check in jt12_slot_seq is enabled by JT12_SLOT_CHECK_EN.
package jt12_slot_pkg;

    localparam int SLOT_W    = 5;
    localparam int OP_W      = 2;
    localparam int CH_W      = 3;
    localparam int FRAME_6CH = 24;
    localparam int FRAME_3CH = 12;

    typedef logic [SLOT_W-1:0] slot_t;
    typedef logic [OP_W-1:0]   op_t;
    typedef logic [CH_W-1:0]   ch_t;

    localparam slot_t LAST_6CH = 5'b11110;
    localparam slot_t LAST_3CH = 5'b11010;

    function automatic logic [3:0] onehot_op(input op_t op);
        return 4'b0001 << op;
    endfunction

    function automatic slot_t last_code(input int num_ch);
        return (num_ch == 3) ? LAST_3CH : LAST_6CH;
    endfunction

    // 6ch skips ch codes 3 and 7; 3ch only uses 0..2
    function automatic logic slot_legal(input slot_t s, input int num_ch);
        if (num_ch == 3)
            return s[2:0] <= 3'd2;
        return s[1:0] != 2'd3;
    endfunction

endpackage

// File: rtl/jt12_slot_next.sv
// Combinational next-slot function: channels step fast, operator
// advances on the last channel of the frame row.
module jt12_slot_next
    import jt12_slot_pkg::*;
#(
    parameter int NUM_CH = 6
) (
    input  logic [SLOT_W-1:0] cur,
    output logic [SLOT_W-1:0] nxt
);

    ch_t ch;
    ch_t a;
    op_t op;

    always_comb begin
        ch = cur[2:0];
        op = cur[4:3];
        a  = ch + 3'd1;
        nxt = cur;
        if (NUM_CH == 3) begin
            nxt[2:0] = (ch == 3'd2) ? 3'd0 : a;
            nxt[4:3] = (ch == 3'd2) ? op + 2'd1 : op;
        end else begin
            nxt[2:0] = (a[1:0] == 2'd3) ? a + 3'd1 : a;
            nxt[4:3] = (ch == 3'd6) ? op + 2'd1 : op;
        end
    end

endmodule

// File: rtl/jt12_slot_seq.sv
// FM operator slot sequencer with frame markers and slot-code delay line.
// Define JT12_SLOT_CHECK_EN to add the illegal-code trap and slot_err output.
module jt12_slot_seq
    import jt12_slot_pkg::*;
#(
    parameter int NUM_CH = 6,
    parameter int STAGES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  restart,
    output logic [SLOT_W-1:0]     slot,
    output logic [3:0]            op_hot,
    output logic                  zero,
    output logic                  zero_pulse,
    output logic                  last,
    output logic [5*STAGES-1:0]   slot_dly
`ifdef JT12_SLOT_CHECK_EN
    ,
    output logic                  slot_err
`endif
);

    localparam slot_t LAST = last_code(NUM_CH);

    slot_t nxt;
    slot_t dly_q [STAGES];
    logic  realign;

    jt12_slot_next #(
        .NUM_CH (NUM_CH)
    ) u_next (
        .cur (slot),
        .nxt (nxt)
    );

`ifdef JT12_SLOT_CHECK_EN
    logic bad;

    assign bad     = clk_en && !slot_legal(slot, NUM_CH);
    assign realign = restart || bad;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            slot_err <= 1'b0;
        else if (restart)
            slot_err <= 1'b0;
        else if (bad)
            slot_err <= 1'b1;
    end
`else
    assign realign = restart;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot       <= '0;
            op_hot     <= 4'b0001;
            zero       <= 1'b1;
            zero_pulse <= 1'b0;
            last       <= 1'b0;
            for (int k = 0; k < STAGES; k++)
                dly_q[k] <= '0;
        end else if (realign) begin
            slot       <= '0;
            op_hot     <= 4'b0001;
            zero       <= 1'b1;
            zero_pulse <= 1'b1;
            last       <= 1'b0;
            for (int k = 0; k < STAGES; k++)
                dly_q[k] <= '0;
        end else if (clk_en) begin
            slot       <= nxt;
            op_hot     <= onehot_op(nxt[4:3]);
            zero       <= (nxt == '0);
            zero_pulse <= (nxt == '0);
            last       <= (nxt == LAST);
            dly_q[0]   <= slot;
            for (int k = 1; k < STAGES; k++)
                dly_q[k] <= dly_q[k-1];
        end else begin
            zero_pulse <= 1'b0;
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_dly
        assign slot_dly[5*g +: 5] = dly_q[g];
    end

endmodule

// File: tb/tb_jt12_slot_seq.sv
// Bench for jt12_slot_seq: 6ch and 3ch instances, vector table plus
// an index-based frame model driven by random stimulus.
module tb_jt12_slot_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b0;
    logic restart = 1'b0;

    logic [4:0]  slot6, slot3;
    logic [3:0]  oh6, oh3;
    logic        z6, z3, zp6, zp3, l6, l3;
    logic [19:0] sd6, sd3;
`ifdef JT12_SLOT_CHECK_EN
    logic        err6, err3;
`endif

    always #5 clk = ~clk;

    jt12_slot_seq #(.NUM_CH(6), .STAGES(4)) dut6 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .restart    (restart),
        .slot       (slot6),
        .op_hot     (oh6),
        .zero       (z6),
        .zero_pulse (zp6),
        .last       (l6),
        .slot_dly   (sd6)
`ifdef JT12_SLOT_CHECK_EN
        ,
        .slot_err   (err6)
`endif
    );

    jt12_slot_seq #(.NUM_CH(3), .STAGES(4)) dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .clk_en     (clk_en),
        .restart    (restart),
        .slot       (slot3),
        .op_hot     (oh3),
        .zero       (z3),
        .zero_pulse (zp3),
        .last       (l3),
        .slot_dly   (sd3)
`ifdef JT12_SLOT_CHECK_EN
        ,
        .slot_err   (err3)
`endif
    );

    logic [4:0]  s_a  [2];
    logic [3:0]  oh_a [2];
    logic        z_a  [2];
    logic        zp_a [2];
    logic        l_a  [2];
    logic [19:0] sd_a [2];

    assign s_a[0]  = slot6;
    assign s_a[1]  = slot3;
    assign oh_a[0] = oh6;
    assign oh_a[1] = oh3;
    assign z_a[0]  = z6;
    assign z_a[1]  = z3;
    assign zp_a[0] = zp6;
    assign zp_a[1] = zp3;
    assign l_a[0]  = l6;
    assign l_a[1]  = l3;
    assign sd_a[0] = sd6;
    assign sd_a[1] = sd3;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: position in frame plus history of codes, per instance
    int         idx  [2];
    logic [4:0] md   [2][4];
    logic       mzp  [2];
    logic       merr [2];

    function automatic int nch_of(input int m);
        return (m == 0) ? 6 : 3;
    endfunction

    function automatic logic [4:0] code_of(input int m, input int i);
        int n, c;
        n = nch_of(m);
        c = i % n;
        if (m == 0 && c >= 3)
            c = c + 1;
        return 5'((i / n) * 8 + c);
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            idx[m]  = 0;
            mzp[m]  = 1'b0;
            merr[m] = 1'b0;
            for (int k = 0; k < 4; k++)
                md[m][k] = '0;
        end
    endtask

    task automatic model_step(input bit en, input bit rs);
        for (int m = 0; m < 2; m++) begin
            if (rs) begin
                idx[m]  = 0;
                mzp[m]  = 1'b1;
                merr[m] = 1'b0;
                for (int k = 0; k < 4; k++)
                    md[m][k] = '0;
            end else if (en) begin
                for (int k = 3; k > 0; k--)
                    md[m][k] = md[m][k-1];
                md[m][0] = code_of(m, idx[m]);
                idx[m] = (idx[m] + 1) % (nch_of(m) * 4);
                mzp[m] = (idx[m] == 0);
            end else begin
                mzp[m] = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int m = 0; m < 2; m++) begin
            string p;
            p = $sformatf("%s_%0dch", tag, nch_of(m));
            chk({p, "_slot"}, s_a[m], code_of(m, idx[m]));
            chk({p, "_op_hot"}, oh_a[m], 4'b0001 << (idx[m] / nch_of(m)));
            chk({p, "_zero"}, z_a[m], idx[m] == 0);
            chk({p, "_last"}, l_a[m], idx[m] == nch_of(m) * 4 - 1);
            chk({p, "_zero_pulse"}, zp_a[m], mzp[m]);
            for (int k = 0; k < 4; k++)
                chk($sformatf("%s_dly%0d", p, k), sd_a[m][5*k +: 5], md[m][k]);
        end
`ifdef JT12_SLOT_CHECK_EN
        chk({tag, "_err6"}, err6, merr[0]);
        chk({tag, "_err3"}, err3, merr[1]);
`endif
    endtask

    task automatic cycle(input bit en, input bit rs, input string tag);
        @(negedge clk);
        clk_en  = en;
        restart = rs;
        @(posedge clk);
        model_step(en, rs);
        #1;
        check_all(tag);
    endtask

    typedef struct {
        bit         en;
        bit         rs;
        logic [4:0] s6;
        logic [4:0] s3;
        bit         zp;
    } vec_t;

    vec_t vecs [10];

    int pulses6, pulses3, wide, lasts6;
    bit prev_zp;

    initial begin
        vecs[0] = '{1, 0, 5'h01, 5'h01, 0};
        vecs[1] = '{0, 0, 5'h01, 5'h01, 0};
        vecs[2] = '{1, 0, 5'h02, 5'h02, 0};
        vecs[3] = '{1, 0, 5'h04, 5'h08, 0};
        vecs[4] = '{0, 1, 5'h00, 5'h00, 1};
        vecs[5] = '{0, 1, 5'h00, 5'h00, 1};
        vecs[6] = '{1, 0, 5'h01, 5'h01, 0};
        vecs[7] = '{1, 1, 5'h00, 5'h00, 1};
        vecs[8] = '{1, 0, 5'h01, 5'h01, 0};
        vecs[9] = '{0, 0, 5'h01, 5'h01, 0};

        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            cycle(vecs[i].en, vecs[i].rs, "vec");
            chk($sformatf("vec%0d_slot6", i), slot6, vecs[i].s6);
            chk($sformatf("vec%0d_slot3", i), slot3, vecs[i].s3);
            chk($sformatf("vec%0d_zp6", i), zp6, vecs[i].zp);
            chk($sformatf("vec%0d_zp3", i), zp3, vecs[i].zp);
        end

        // Full frame from slot 0
        cycle(0, 1, "frm_rst");
        pulses6 = 0;
        pulses3 = 0;
        lasts6  = 0;
        for (int i = 1; i <= 24; i++) begin
            cycle(1, 0, "frame");
            pulses6 += int'(zp6);
            pulses3 += int'(zp3);
            lasts6  += int'(l6);
            if (i == 11) chk("frame3_last_code", slot3, 5'h1A);
            if (i == 11) chk("frame3_last_flag", l3, 1'b1);
            if (i == 12) chk("frame3_wrap", slot3, 5'h00);
            if (i == 23) chk("frame6_last_code", slot6, 5'h1E);
            if (i == 23) chk("frame6_last_flag", l6, 1'b1);
            if (i == 24) chk("frame6_wrap", slot6, 5'h00);
            if (i == 24) chk("frame6_wrap_zp", zp6, 1'b1);
        end
        chk("frame6_pulse_count", pulses6, 1);
        chk("frame3_pulse_count", pulses3, 2);
        chk("frame6_last_count", lasts6, 1);

        // Sparse enable: one edge in four
        cycle(0, 1, "sp_rst");
        pulses6 = 0;
        wide    = 0;
        prev_zp = 1'b0;
        for (int i = 0; i < 100; i++) begin
            cycle(i % 4 == 0, 0, "sparse");
            pulses6 += int'(zp6);
            if (prev_zp && zp6) wide++;
            prev_zp = zp6;
        end
        chk("sparse_pulse_count", pulses6, 1);
        chk("sparse_pulse_wide", wide, 0);

        // Restart at 0x0D
        cycle(0, 1, "rs_rst");
        for (int i = 0; i < 10; i++)
            cycle(1, 0, "rs_run");
        chk("rs_at_0d", slot6, 5'h0D);
        cycle(1, 1, "rs_hit");
        chk("rs_slot", slot6, 5'h00);
        chk("rs_zp", zp6, 1'b1);
        chk("rs_dly", sd6, 20'h0);
        cycle(1, 0, "rs_after");
        chk("rs_after_slot", slot6, 5'h01);
        chk("rs_after_dly0", sd6[4:0], 5'h00);

        // Random stimulus against the model
        for (int i = 0; i < 400; i++)
            cycle($urandom % 3 != 0, $urandom % 40 == 0, "rand");

        // Asynchronous reset mid-frame, checked before any edge
        cycle(1, 0, "pre_arst");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        clk_en = 1'b0;
        restart = 1'b0;
        rst_n = 1'b1;
        cycle(1, 0, "post_arst");
        chk("post_arst_slot6", slot6, 5'h01);

`ifdef JT12_SLOT_CHECK_EN
        cycle(0, 1, "err_rst");
        @(negedge clk);
        clk_en  = 1'b0;
        restart = 1'b0;
        force dut6.slot = 5'h03;
        force dut3.slot = 5'h03;
        @(posedge clk);
        #1;
        release dut6.slot;
        release dut3.slot;
        @(negedge clk);
        clk_en = 1'b1;
        @(posedge clk);
        model_step(0, 1);
        merr[0] = 1'b1;
        merr[1] = 1'b1;
        #1;
        check_all("err_trap");
        cycle(1, 0, "err_hold");
        cycle(0, 0, "err_hold2");
        cycle(0, 1, "err_clear");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
